// File: rtl/dcollide_pkg.sv
// Shared types and constants for the sphere-pair collision front end.
// Field order inside a record: x1,y1,z1,r1,x2,y2,z2,r2 (x1 in the low word).
package dcollide_pkg;
    localparam int WORD_W = 32;
    localparam int FIELDS = 8;

    localparam logic [2:0] F_X1 = 3'd0;
    localparam logic [2:0] F_Y1 = 3'd1;
    localparam logic [2:0] F_Z1 = 3'd2;
    localparam logic [2:0] F_R1 = 3'd3;
    localparam logic [2:0] F_X2 = 3'd4;
    localparam logic [2:0] F_Y2 = 3'd5;
    localparam logic [2:0] F_Z2 = 3'd6;
    localparam logic [2:0] F_R2 = 3'd7;

    localparam logic [1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] MODE_LOOP     = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [FIELDS-1:0][WORD_W-1:0] rec_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    function automatic rec_t pack_rec(
        input word_t x1, input word_t y1,
        input word_t z1, input word_t r1,
        input word_t x2, input word_t y2,
        input word_t z2, input word_t r2
    );
        rec_t r;
        r[F_X1] = x1;
        r[F_Y1] = y1;
        r[F_Z1] = z1;
        r[F_R1] = r1;
        r[F_X2] = x2;
        r[F_Y2] = y2;
        r[F_Z2] = z2;
        r[F_R2] = r2;
        return r;
    endfunction
endpackage

// File: rtl/sphere_pair_feeder_if.sv
// Host load port plus pipeline-side valid/ready stream of the feeder.
interface sphere_pair_feeder_if #(
    parameter int DEPTH = 16
);
    import dcollide_pkg::*;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        wr_field;
    word_t             wr_data;
    logic [1:0]        mode;
    logic [ADDR_W:0]   len;
    logic              start;
    logic              stop;
    logic              out_valid;
    logic              out_ready;
    rec_t              out_pair;
    logic [ADDR_W-1:0] out_index;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       pass_count;

    modport master (
        output wr_en, wr_addr, wr_field, wr_data,
        output mode, len, start, stop, out_ready,
        input  out_valid, out_pair, out_index,
        input  busy, done, err, pass_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_field, wr_data,
        input  mode, len, start, stop, out_ready,
        output out_valid, out_pair, out_index,
        output busy, done, err, pass_count
    );
endinterface

// File: rtl/sphere_pair_store.sv
// Record store: per-field write port, full-record combinational read.
module sphere_pair_store
    import dcollide_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [2:0]        i_wr_field,
    input  word_t             i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output rec_t              o_rd_rec
);
    rec_t r_mem [DEPTH];

    // Contents intentionally survive reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr][i_wr_field] <= i_wr_data;
        end
    end

    assign o_rd_rec = r_mem[i_rd_addr];
endmodule

// File: rtl/sphere_pair_feeder.sv
// Sequences stored sphere-pair records into the collision pipeline.
module sphere_pair_feeder
    import dcollide_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input logic CLOCK_50,
    input logic rst,
    sphere_pair_feeder_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    typedef logic [ADDR_W-1:0] idx_t;
    typedef logic [ADDR_W:0]   len_t;
    localparam idx_t IDX_ONE = idx_t'(1);
    localparam len_t LEN_ONE = len_t'(1);
    localparam len_t LEN_MAX = len_t'(DEPTH);

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_mode,  w_mode_nxt;
    len_t        r_len,   w_len_nxt;
    idx_t        r_idx,   w_idx_nxt;
    logic        r_up,    w_up_nxt;
    logic        r_stop,  w_stop_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_err,   w_err_nxt;
    logic [15:0] r_pass,  w_pass_nxt;
    rec_t        r_pair;

    logic        w_load;
    idx_t        w_rd_addr;
    rec_t        w_rd_rec;
    logic        w_xfer;
    logic        w_at_end;
    logic        w_bounce;
    idx_t        w_step_idx;
    logic        w_step_up;
    logic [15:0] w_pass_inc;

    sphere_pair_store #(.DEPTH(DEPTH)) u_store (
        .i_clk      (CLOCK_50),
        .i_wr_en    (bus.wr_en),
        .i_wr_addr  (bus.wr_addr),
        .i_wr_field (bus.wr_field),
        .i_wr_data  (bus.wr_data),
        .i_rd_addr  (w_rd_addr),
        .o_rd_rec   (w_rd_rec)
    );

    assign w_xfer     = r_valid && bus.out_ready;
    assign w_at_end   = ({1'b0, r_idx} == (r_len - LEN_ONE));
    assign w_bounce   = (r_mode == MODE_PINGPONG) && (r_len != LEN_ONE);
    assign w_pass_inc = (r_pass == 16'hFFFF) ? r_pass : r_pass + 16'd1;

    // Next slot; ping-pong flips direction on landing at either end.
    always_comb begin
        w_step_idx = '0;
        w_step_up  = r_up;
        if (w_bounce) begin
            w_step_idx = r_up ? r_idx + IDX_ONE : r_idx - IDX_ONE;
            if (w_step_idx == '0) begin
                w_step_up = 1'b1;
            end else if ({1'b0, w_step_idx} == (r_len - LEN_ONE)) begin
                w_step_up = 1'b0;
            end
        end else begin
            w_step_idx = w_at_end ? '0 : r_idx + IDX_ONE;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_len_nxt   = r_len;
        w_idx_nxt   = r_idx;
        w_up_nxt    = r_up;
        w_stop_nxt  = r_stop;
        w_valid_nxt = r_valid;
        w_pass_nxt  = r_pass;
        w_err_nxt   = 1'b0;
        w_load      = 1'b0;
        w_rd_addr   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    if (bus.len == '0 || bus.len > LEN_MAX) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_mode_nxt  = (bus.mode == MODE_LOOP ||
                                       bus.mode == MODE_PINGPONG) ?
                                      bus.mode : MODE_ONESHOT;
                        w_len_nxt   = bus.len;
                        w_pass_nxt  = '0;
                        w_idx_nxt   = '0;
                        w_up_nxt    = 1'b1;
                        w_stop_nxt  = 1'b0;
                        w_valid_nxt = 1'b1;
                        w_load      = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    w_stop_nxt = 1'b1;
                end
                if (w_xfer) begin
                    if (r_stop || bus.stop ||
                        (r_mode == MODE_ONESHOT && w_at_end)) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_DONE;
                        if (r_mode == MODE_ONESHOT && w_at_end) begin
                            w_pass_nxt = w_pass_inc;
                        end
                    end else begin
                        w_idx_nxt = w_step_idx;
                        w_up_nxt  = w_step_up;
                        w_load    = 1'b1;
                        w_rd_addr = w_step_idx;
                        if (w_step_idx == '0) begin
                            w_pass_nxt = w_pass_inc;
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_stop_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= MODE_ONESHOT;
            r_len   <= '0;
            r_idx   <= '0;
            r_up    <= 1'b1;
            r_stop  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_pass  <= '0;
            r_pair  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_len   <= w_len_nxt;
            r_idx   <= w_idx_nxt;
            r_up    <= w_up_nxt;
            r_stop  <= w_stop_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_pass  <= w_pass_nxt;
            if (w_load) begin
                r_pair <= w_rd_rec;
            end
        end
    end

    assign bus.out_valid  = r_valid;
    assign bus.out_pair   = r_pair;
    assign bus.out_index  = r_idx;
    assign bus.busy       = (r_state == S_RUN);
    assign bus.done       = (r_state == S_DONE);
    assign bus.err        = r_err;
    assign bus.pass_count = r_pass;
endmodule
